// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants, state encoding and skew helper for the systolic feed controller
package systolic_pkg;
   localparam int N = 4;
   localparam int DW = 8;
   localparam int FEED_LEN = 2 * N - 1;
   localparam int AW = $clog2(N * N);
   localparam int LW = $clog2(N);
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_FIN} state_t;
   typedef struct packed {
      logic v;
      logic [LW-1:0] idx;
   } skew_t;
   // Element offset t-lane; unsigned underflow lands far above N and reads as invalid
   function automatic skew_t skew_idx(input logic [3:0] t, input logic [LW-1:0] lane);
      logic [4:0] d;
      d = 5'(t) - 5'(lane);
      return '{v: d < 5'(N), idx: d[LW-1:0]};
   endfunction
endpackage

// File: rtl/systolic_feed_ctrl_bank.sv
// operand_bank: N*N element register file, one sync write port, sync clear, N comb read ports
module operand_bank
   import systolic_pkg::*;
(
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     we,
   input  logic [AW-1:0]            waddr,
   input  logic [DW-1:0]            wdata,
   input  logic [N-1:0][AW-1:0]     raddr,
   output logic [N-1:0][DW-1:0]     rdata
);
   logic [N*N-1:0][DW-1:0] mem;
   // Storage: clear wins over write
   always_ff @(posedge clk) begin
      if (clr) mem <= '0;
      else if (we) mem[waddr] <= wdata;
   end
   for (genvar g = 0; g < N; g++) begin : g_rd
      assign rdata[g] = mem[raddr[g]];
   end
endmodule

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: loads A/B operands, then clears, feeds a skewed wavefront, drains and signals done
module systolic_feed_ctrl
   import systolic_pkg::*;
#(
   parameter int DRAIN = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              wr_sel,
   input  logic [3:0]        wr_addr,
   input  logic [DW-1:0]     wr_data,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              arr_clr,
   output logic              arr_en,
   output logic [N*DW-1:0]   a_out,
   output logic [N*DW-1:0]   b_out,
   output logic [3:0]        step
);
   state_t state, state_n;
   logic [3:0] cnt, cnt_n, step_n;
   logic busy_n, done_n, clr_n, en_n, feed_n;
   logic [N-1:0][AW-1:0] a_ra, b_ra;
   logic [N-1:0][DW-1:0] a_rd, b_rd;
   logic [N*DW-1:0] a_n, b_n;
   skew_t [N-1:0] sk;
   operand_bank u_bank_a (
      .clk(clk), .clr(reset), .we(wr_en && !wr_sel && state == S_IDLE),
      .waddr(wr_addr), .wdata(wr_data), .raddr(a_ra), .rdata(a_rd)
   );
   operand_bank u_bank_b (
      .clk(clk), .clr(reset), .we(wr_en && wr_sel && state == S_IDLE),
      .waddr(wr_addr), .wdata(wr_data), .raddr(b_ra), .rdata(b_rd)
   );
   // Lane i of A reads row i, lane j of B reads column j, both at offset t-lane
   for (genvar i = 0; i < N; i++) begin : g_lane
      assign sk[i] = skew_idx(cnt_n, LW'(i));
      assign a_ra[i] = {LW'(i), sk[i].idx};
      assign b_ra[i] = {sk[i].idx, LW'(i)};
      assign a_n[DW*i +: DW] = (feed_n && sk[i].v) ? a_rd[i] : '0;
      assign b_n[DW*i +: DW] = (feed_n && sk[i].v) ? b_rd[i] : '0;
   end
   // State, counter and registered outputs; outputs track the state being entered
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         arr_clr <= 1'b0;
         arr_en <= 1'b0;
         a_out <= '0;
         b_out <= '0;
         step <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         busy <= busy_n;
         done <= done_n;
         arr_clr <= clr_n;
         arr_en <= en_n;
         a_out <= a_n;
         b_out <= b_n;
         step <= step_n;
      end
   end
   // Next state; cnt counts feed steps in FEED and drain cycles in DRAIN
   always_comb begin
      state_n = state;
      cnt_n = '0;
      case (state)
         S_IDLE: state_n = start ? S_CLEAR : S_IDLE;
         S_CLEAR: state_n = S_FEED;
         S_FEED: begin
            state_n = (cnt == 4'(FEED_LEN - 1)) ? S_DRAIN : S_FEED;
            cnt_n = (cnt == 4'(FEED_LEN - 1)) ? '0 : cnt + 4'd1;
         end
         S_DRAIN: begin
            state_n = (cnt == 4'(DRAIN - 1)) ? S_FIN : S_DRAIN;
            cnt_n = (cnt == 4'(DRAIN - 1)) ? '0 : cnt + 4'd1;
         end
         S_FIN: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end
   // Output values for the upcoming state
   always_comb begin
      feed_n = state_n == S_FEED;
      busy_n = state_n != S_IDLE;
      done_n = state_n == S_FIN;
      clr_n = state_n == S_CLEAR;
      en_n = feed_n || state_n == S_DRAIN;
      step_n = feed_n ? cnt_n : '0;
   end
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: randomized self-checking bench against a matrix-level reference model
module tb_systolic_feed_ctrl;
   import systolic_pkg::*;
   localparam int DRN = 4;
   localparam int FIN_K = 2 * N + DRN;
   logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic busy, done, arr_clr, arr_en;
   logic [N*DW-1:0] a_out, b_out;
   logic [3:0] step;
   int errs = 0, checks = 0;
   int ma[N*N], mb[N*N];

   systolic_feed_ctrl #(.DRAIN(DRN)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .busy(busy), .done(done), .arr_clr(arr_clr),
      .arr_en(arr_en), .a_out(a_out), .b_out(b_out), .step(step)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N*DW-1:0] lanes(input int t, input bit isb);
      logic [N*DW-1:0] r = '0;
      for (int l = 0; l < N; l++) begin
         int d = t - l;
         if (t >= 0 && d >= 0 && d < N) r[DW*l +: DW] = DW'(isb ? mb[d*N+l] : ma[l*N+d]);
      end
      return r;
   endfunction

   // k = cycles since accept: 0 clear, 1..2N-1 feed, then drain, FIN_K done, beyond idle
   task automatic expect_k(input int k, input string tag);
      int t = (k >= 1 && k <= 2 * N - 1) ? k - 1 : -1;
      chk({tag, ".clr"}, arr_clr, k == 0);
      chk({tag, ".en"}, arr_en, k >= 1 && k < FIN_K);
      chk({tag, ".done"}, done, k == FIN_K);
      chk({tag, ".busy"}, busy, k <= FIN_K);
      chk({tag, ".step"}, step, t >= 0 ? t : 0);
      chk({tag, ".a"}, a_out, lanes(t, 1'b0));
      chk({tag, ".b"}, b_out, lanes(t, 1'b1));
   endtask

   task automatic wr(input bit sel, input int addr, input int data);
      wr_en = 1'b1;
      wr_sel = sel;
      wr_addr = 4'(addr);
      wr_data = DW'(data);
      tick;
      wr_en = 1'b0;
      if (sel) mb[addr] = data & 8'hFF;
      else ma[addr] = data & 8'hFF;
   endtask

   task automatic run(input string tag, input bit junk, input bit hold, input bit do_wr,
                      input bit sel, input int addr, input int data);
      start = 1'b1;
      if (do_wr) begin
         wr_en = 1'b1;
         wr_sel = sel;
         wr_addr = 4'(addr);
         wr_data = DW'(data);
         if (sel) mb[addr] = data & 8'hFF;
         else ma[addr] = data & 8'hFF;
      end
      tick;
      wr_en = 1'b0;
      start = hold;
      for (int k = 0; k <= FIN_K; k++) begin
         expect_k(k, $sformatf("%s.k%0d", tag, k));
         if (junk && k < FIN_K) begin
            start = 1'($urandom);
            wr_en = 1'($urandom);
            wr_sel = 1'($urandom);
            wr_addr = 4'($urandom);
            wr_data = DW'($urandom);
         end else begin
            start = hold;
            wr_en = 1'b0;
         end
         tick;
      end
      expect_k(FIN_K + 1, {tag, ".idle"});
   endtask

   initial begin
      for (int i = 0; i < N * N; i++) begin
         ma[i] = 0;
         mb[i] = 0;
      end
      tick;
      tick;
      expect_k(99, "rst");
      reset = 1'b0;
      tick;
      expect_k(99, "idle0");
      run("zero", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < N * N; i++) begin
         wr(1'b0, i, 1);
         wr(1'b1, i, 1);
      end
      run("ones", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < N * N; i++) begin
         wr(1'b0, i, (i / N == i % N) ? 1 : 0);
         wr(1'b1, i, i + 1);
      end
      run("ident", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      run("ident2", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      run("samecyc", 1'b0, 1'b0, 1'b1, 1'b0, 15, 'hFF);
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N * N; i++) begin
            wr(1'b0, i, int'($urandom_range(0, 255)));
            wr(1'b1, i, int'($urandom_range(0, 255)));
         end
         run($sformatf("rand%0d", r), 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      end
      for (int r = 0; r < 3; r++) run($sformatf("hold%0d", r), 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      start = 1'b0;
      tick;
      expect_k(99, "holdend");
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         expect_k(k, $sformatf("pre_rst.k%0d", k));
         tick;
      end
      expect_k(5, "pre_rst.k5");
      reset = 1'b1;
      tick;
      reset = 1'b0;
      for (int i = 0; i < N * N; i++) begin
         ma[i] = 0;
         mb[i] = 0;
      end
      expect_k(99, "midrst");
      for (int k = 0; k < FIN_K + 2; k++) begin
         tick;
         chk($sformatf("nodone.k%0d", k), {busy, done}, 2'b00);
      end
      run("cleared", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
